// File: rtl/sdram_ctrl_pkg.sv
// Shared types and constants for the SDRAM line-buffer fetch path.
// Frame geometry defaults describe the 800x480 MTL panel.
package sdram_ctrl_pkg;

  localparam int LINE_WORDS      = 800;
  localparam int FRAME_LINES     = 480;
  localparam int DEF_FRAME_WORDS = LINE_WORDS * FRAME_LINES;
  localparam int DEF_SEG_WORDS   = 160;
  localparam int DEF_AW          = 23;
  localparam int DEF_DW          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sdram_frame_addr_ctr.sv
// SDRAM frame read-address counter: loads the frame base, steps by one
// segment, and wraps back to the base when the next segment would leave the frame.
module sdram_frame_addr_ctr
  import sdram_ctrl_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int SEG_WORDS   = DEF_SEG_WORDS,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iLOAD,
  input  logic          iADVANCE,
  input  logic [AW-1:0] iBASE_ADDR,
  output logic [AW-1:0] oADDR
);

  // One extra bit so base+frame size near the top of SDRAM cannot alias low.
  logic [AW:0] next_sum;
  logic [AW:0] frame_end;

  assign next_sum  = {1'b0, oADDR} + (AW+1)'(SEG_WORDS);
  assign frame_end = {1'b0, iBASE_ADDR} + (AW+1)'(FRAME_WORDS);

  always_ff @(posedge iCLK) begin
    if (iRST || iLOAD) begin
      oADDR <= iBASE_ADDR;
    end else if (iADVANCE) begin
      if (next_sum >= frame_end) begin
        oADDR <= iBASE_ADDR;
      end else begin
        oADDR <= next_sum[AW-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_line_fetch.sv
// Line-buffer refill engine: acknowledges the sticky refill request, reads one
// segment from SDRAM and streams it to the line-buffer RAM with one cycle of latency.
module sdram_line_fetch
  import sdram_ctrl_pkg::*;
#(
  parameter int SEG_WORDS   = DEF_SEG_WORDS,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iREQ,
  output logic          oREQ_CLR,
  input  logic          iFRAME_START,
  input  logic [AW-1:0] iBASE_ADDR,
  output logic          oRD_REQ,
  output logic [AW-1:0] oRD_ADDR,
  output logic [7:0]    oRD_LEN,
  input  logic          iRD_ACK,
  input  logic          iRD_VALID,
  input  logic [DW-1:0] iRD_DATA,
  output logic          oEN_W,
  output logic [DW-1:0] oDATA_W,
  output logic          oBUSY,
  output logic [1:0]    oDBG_STATE
);

  // Read port handshake: oRD_REQ rises with oRD_ADDR/oRD_LEN valid and holds
  // them until a one-cycle iRD_ACK; each iRD_VALID cycle in DATA is one word.

  fetch_state_t state;
  logic [7:0]   word_cnt;
  logic         last_beat;
  logic         seg_done;

  assign oRD_LEN    = 8'(SEG_WORDS);
  assign oDBG_STATE = state;
  assign last_beat  = (state == DATA) && iRD_VALID && (word_cnt == 8'(SEG_WORDS - 1));
  assign seg_done   = last_beat && !iFRAME_START;

  sdram_frame_addr_ctr #(
    .AW          (AW),
    .SEG_WORDS   (SEG_WORDS),
    .FRAME_WORDS (FRAME_WORDS)
  ) u_addr_ctr (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iLOAD      (iFRAME_START),
    .iADVANCE   (seg_done),
    .iBASE_ADDR (iBASE_ADDR),
    .oADDR      (oRD_ADDR)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      oREQ_CLR <= 1'b0;
      oRD_REQ  <= 1'b0;
      oEN_W    <= 1'b0;
      oDATA_W  <= '0;
      oBUSY    <= 1'b0;
      word_cnt <= '0;
    end else if (iFRAME_START) begin
      // Abort: beats still in flight arrive in IDLE and are dropped.
      state    <= IDLE;
      oREQ_CLR <= 1'b0;
      oRD_REQ  <= 1'b0;
      oEN_W    <= 1'b0;
      oBUSY    <= 1'b0;
      word_cnt <= '0;
    end else begin
      oREQ_CLR <= 1'b0;
      oEN_W    <= 1'b0;
      case (state)
        IDLE: begin
          if (iREQ) begin
            oREQ_CLR <= 1'b1;
            oRD_REQ  <= 1'b1;
            oBUSY    <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (iRD_ACK) begin
            oRD_REQ  <= 1'b0;
            word_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (iRD_VALID) begin
            oEN_W   <= 1'b1;
            oDATA_W <= iRD_DATA;
            if (last_beat) begin
              word_cnt <= '0;
              oBUSY    <= 1'b0;
              state    <= IDLE;
            end else begin
              word_cnt <= word_cnt + 8'd1;
            end
          end
        end
        default: begin
          oRD_REQ  <= 1'b0;
          oBUSY    <= 1'b0;
          word_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_line_fetch.md
Name: sdram_line_fetch

Overview:
- Write-side responder to the line-buffer read-address generator in the MTL photo path.
- Consumes that generator's sticky refill request, clears it, and fetches one line segment (SEG_WORDS pixels) from SDRAM through a read port.
- Streams the returned pixels into the line-buffer RAM as write-enable/data; the write address counter stays in the address generator.
- Tracks the SDRAM frame read address, wrapping at frame end and rebasing on frame start.

Parameters:
- SEG_WORDS, 160, words per refill request (one fifth of an 800-pixel line); legal range 1..255.
- FRAME_WORDS, 384000, words per frame (800x480).
- AW, 23, SDRAM word-address width.
- DW, 16, pixel data width.

Ports:
- iCLK  in  1  single system clock; all logic is on its rising edge.
- iRST  in  1  synchronous, active-high reset.
- iREQ  in  1  sticky line-buffer refill request, level; held high until oREQ_CLR.
- oREQ_CLR  out  1  one-cycle pulse acknowledging iREQ.
- iFRAME_START  in  1  one-cycle pulse; restart address at iBASE_ADDR.
- iBASE_ADDR  in  AW  frame base word address in SDRAM; sampled on iRST and iFRAME_START.
- oRD_REQ  out  1  SDRAM read request, held until grant.
- oRD_ADDR  out  AW  burst start address; stable while oRD_REQ is high.
- oRD_LEN  out  8  burst length; constant SEG_WORDS.
- iRD_ACK  in  1  SDRAM read grant, one cycle.
- iRD_VALID  in  1  read data valid.
- iRD_DATA  in  DW  read data.
- oEN_W  out  1  line-buffer write enable (to the address generator and RAM).
- oDATA_W  out  DW  line-buffer write data.
- oBUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous): state IDLE.
- Reset values: oREQ_CLR=0, oRD_REQ=0, oEN_W=0, oDATA_W=0, oBUSY=0, word count=0.
- Reset values: oRD_ADDR=iBASE_ADDR; oRD_LEN=SEG_WORDS always.
- FSM states: IDLE, REQ, DATA.
- IDLE, iREQ=1 and iFRAME_START=0: next cycle oREQ_CLR=1 for exactly one cycle, oRD_REQ=1, state REQ.
- IDLE, iREQ=0: stay IDLE; all outputs are idle values.
- REQ: hold oRD_REQ=1 and oRD_ADDR until iRD_ACK is sampled high.
- REQ, iRD_ACK=1: next cycle oRD_REQ=0, state DATA, word count=0.
- DATA, each cycle with iRD_VALID=1: next cycle oEN_W=1 and oDATA_W=iRD_DATA (1-cycle registered latency); word count increments.
- DATA, iRD_VALID=0: oEN_W=0 next cycle; gaps in valid are allowed and impose no timeout.
- DATA end: on the valid beat with word count = SEG_WORDS-1, return to IDLE next cycle (that beat's oEN_W is still issued).
- DATA end: oRD_ADDR advances by SEG_WORDS.
- Wrap rule: if oRD_ADDR+SEG_WORDS >= iBASE_ADDR+FRAME_WORDS, oRD_ADDR becomes iBASE_ADDR instead.
- Arithmetic: address sums are computed at AW+1 bits; no silent truncation.
- Back-to-back: if iREQ is already high on IDLE entry, the next request starts the following cycle. Minimum one IDLE cycle between segments.
- Requests while busy: iREQ is not cleared while busy; it is held and served on return to IDLE. No request is lost; there is no queue deeper than the sticky flag.
- iRD_VALID outside DATA: ignored; no oEN_W.
- iRD_ACK outside REQ: ignored.
- iFRAME_START (any state): next cycle state IDLE, oRD_REQ=0, word count=0, oRD_ADDR=iBASE_ADDR. The pending oEN_W of the current cycle still completes.
- iFRAME_START priority: wins over iREQ, iRD_ACK and iRD_VALID in the same cycle.
- iFRAME_START during DATA: remaining beats of the aborted burst are dropped, because they arrive in IDLE.
- iRST mid-operation: identical abort; the sticky request is untouched by this block.

Decomposition:
- Shared package sdram_ctrl_pkg holds:
  - FSM state enum (IDLE/REQ/DATA).
  - Constants: LINE_WORDS=800, FRAME_LINES=480, default SEG_WORDS, AW, DW.
- One natural sub-module: sdram_frame_addr_ctr. It holds the base load, advance by SEG_WORDS, and end-of-frame wrap, so the address logic can be verified standalone.

Test Plan:
- Single request: iREQ=1 at idle, base=0 -> oREQ_CLR is one pulse; oRD_REQ=1 with oRD_ADDR=0, oRD_LEN=160 until ACK; 160 valid beats -> exactly 160 oEN_W with data in order, 1-cycle lag; then IDLE with oRD_ADDR=160.
- Valid gaps: toggle iRD_VALID every other cycle -> oEN_W mirrors it delayed one cycle; count still completes at 160 beats.
- Frame wrap: base=1000, oRD_ADDR preset to 1000+384000-160, one segment -> oRD_ADDR returns to 1000.
- Request during busy: raise iREQ at beat 50 of DATA -> no oREQ_CLR until IDLE; second burst starts at addr+160 one cycle after IDLE.
- Frame abort: iFRAME_START at beat 80 with iREQ=1 that cycle -> IDLE next cycle, oRD_ADDR=base, no oEN_W for beats 81+; iREQ served the cycle after.
- Sync reset mid-REQ: iRST high one cycle -> oRD_REQ=0 and oBUSY=0 next cycle; a late iRD_ACK and valids are ignored.
